uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, half-bit-aligned sampling, single-entry holding register
// with overrun and frame-error reporting. All state advances only on ce-qualified clock edges.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] HalfLoad = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FullLoad = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_error_q, frame_error_d;
    logic        overrun_q, overrun_d;
    logic        rx_meta_q, rx_s_q;
    logic        tick;

    assign tick = (baud_q == 16'd0);

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q & ~data_ack;
        frame_error_d = 1'b0;
        overrun_d     = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    bit_d   = 3'd0;
                    baud_d  = HalfLoad;
                end
            end
            StStart: begin
                baud_d = tick ? FullLoad : baud_q - 16'd1;
                if (tick) begin
                    state_d = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                baud_d = tick ? FullLoad : baud_q - 16'd1;
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                baud_d = tick ? FullLoad : baud_q - 16'd1;
                if (tick) begin
                    if (rx_s_q) begin
                        // A same-edge ack consumes the old byte, so only an unacked one overruns
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        overrun_d    = overrun_q | (data_valid_q & ~data_ack);
                        state_d      = StIdle;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            baud_q        <= 16'd0;
            bit_q         <= 3'd0;
            shift_q       <= 8'h00;
            data_out_q    <= 8'h00;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
        end else if (ce) begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=16: clean frames, glitch, break, overrun,
// clock-enable throttling and mid-frame reset.
module tb_uart_rx;

    localparam int unsigned BD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b1;
    logic       rx = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int dv_rise_cyc = 0;
    int fe_pulses = 0;
    int fe_high = 0;
    logic dv_prev = 1'b0;
    logic fe_prev = 1'b0;
    logic ce_toggle = 1'b0;

    uart_rx #(.BAUD_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .rx         (rx),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sample half a period after each active edge.
    always @(negedge clk) begin
        if (data_valid && !dv_prev) dv_rise_cyc = cyc;
        dv_prev = data_valid;
        if (frame_error) fe_high = fe_high + 1;
        if (frame_error && !fe_prev) fe_pulses = fe_pulses + 1;
        fe_prev = frame_error;
        ce = ce_toggle ? ~ce : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts on a negedge; leaves rx at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input int bit_clks, input logic stop_bit,
                             input int stop_clks);
        rx = 1'b0;
        wait_clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(bit_clks);
        end
        rx = stop_bit;
        wait_clks(stop_clks);
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1;
        wait_clks(1);
        data_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wait_clks(2);
        rst = 1'b1;
        wait_clks(2);
    endtask

    int t0;
    int fe_base;
    int feh_base;

    initial begin
        wait_clks(3);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_frame_error", 32'(frame_error), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        wait_clks(4);

        // Clean 0xA5; valid should rise on edge 2 + BD/2 + 9*BD counted from the edge that
        // first captures the low line, i.e. the (BD/2 + 9*BD + 3)-th edge after rx falls.
        fe_base = fe_pulses;
        t0 = cyc;
        send_byte(8'hA5, BD, 1'b1, BD);
        check("a5_data_out", 32'(data_out), 32'hA5);
        check("a5_data_valid", 32'(data_valid), 32'h1);
        check("a5_latency", 32'(dv_rise_cyc - t0), 32'(BD / 2 + 9 * BD + 3));
        check("a5_no_frame_error", 32'(fe_pulses - fe_base), 32'd0);
        check("a5_busy_after", 32'(busy), 32'h0);
        pulse_ack();
        check("a5_ack_clears", 32'(data_valid), 32'h0);

        // Five-cycle glitch: START sample lands after the line has gone high again.
        rx = 1'b0;
        wait_clks(5);
        check("glitch_busy_mid", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_clks(9);
        check("glitch_idle_in_bit", 32'(busy), 32'h0);
        wait_clks(20);
        check("glitch_no_valid", 32'(data_valid), 32'h0);
        check("glitch_no_fe", 32'(fe_pulses - fe_base), 32'd0);

        // 0x3C with stop low, line held low for 40 cycles.
        feh_base = fe_high;
        send_byte(8'h3C, BD, 1'b0, 40);
        check("brk_one_pulse", 32'(fe_pulses - fe_base), 32'd1);
        check("brk_pulse_width", 32'(fe_high - feh_base), 32'd1);
        check("brk_valid_held", 32'(data_valid), 32'h0);
        check("brk_busy_low_line", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_clks(5);
        check("brk_idle_after_high", 32'(busy), 32'h0);
        check("brk_data_out_kept", 32'(data_out), 32'hA5);
        check("brk_still_one_pulse", 32'(fe_pulses - fe_base), 32'd1);

        // Back-to-back bytes with no ack.
        send_byte(8'h11, BD, 1'b1, BD);
        send_byte(8'h22, BD, 1'b1, BD);
        check("ovr_data_out", 32'(data_out), 32'h22);
        check("ovr_valid", 32'(data_valid), 32'h1);
        check("ovr_set", 32'(overrun), 32'h1);

        // Same again, but ack lands on the completion edge of the second byte.
        do_reset();
        check("ovr_cleared_by_reset", 32'(overrun), 32'h0);
        send_byte(8'h11, BD, 1'b1, BD);
        fork
            send_byte(8'h22, BD, 1'b1, BD);
            begin
                wait_clks(BD / 2 + 9 * BD + 2);
                data_ack = 1'b1;
                wait_clks(1);
                data_ack = 1'b0;
            end
        join
        check("ack_data_out", 32'(data_out), 32'h22);
        check("ack_valid_stays", 32'(data_valid), 32'h1);
        check("ack_no_overrun", 32'(overrun), 32'h0);
        pulse_ack();

        // ce at half rate; bit time of 32 clocks is BD ce cycles.
        ce_toggle = 1'b1;
        send_byte(8'h5A, 2 * BD, 1'b1, 2 * BD);
        wait_clks(4);
        ce_toggle = 1'b0;
        wait_clks(2);
        check("ce_data_out", 32'(data_out), 32'h5A);
        check("ce_valid", 32'(data_valid), 32'h1);

        // Reset in the middle of data bit 4 of 0xFF.
        fork
            send_byte(8'hFF, BD, 1'b1, BD);
            begin
                wait_clks(5 * BD + BD / 2);
                rst = 1'b0;
                #1;
                check("mid_rst_data_out", 32'(data_out), 32'h00);
                check("mid_rst_valid", 32'(data_valid), 32'h0);
                check("mid_rst_busy", 32'(busy), 32'h0);
                wait_clks(3);
                rst = 1'b1;
            end
        join
        wait_clks(4);
        check("mid_rst_partial_dropped", 32'(data_valid), 32'h0);
        check("mid_rst_idle", 32'(busy), 32'h0);
        fe_base = fe_pulses;
        send_byte(8'h81, BD, 1'b1, BD);
        check("post_rst_data_out", 32'(data_out), 32'h81);
        check("post_rst_valid", 32'(data_valid), 32'h1);
        check("post_rst_no_fe", 32'(fe_pulses - fe_base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
